// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants, FSM encoding and the reverse-Rcon helper
//                for the AES-128 inverse key schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int BYTE = 8;
    localparam int WORD = 32;
    localparam int NK   = 4;
    localparam int NR   = 10;

    localparam logic [BYTE-1:0] RCON_LAST  = 8'h36;
    localparam logic [3:0]      ROUND_LAST = 4'(NR);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Division by x in GF(2^8): exact inverse of xtime.
    function automatic logic [BYTE-1:0] inv_xtime(input logic [BYTE-1:0] x);
        if (x[0]) begin
            return ((x ^ 8'h1B) >> 1) | 8'h80;
        end
        return x >> 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  Module      : aes_sbox
//  Description : Combinational AES forward S-box, one byte in, one byte out.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_sbox (
    input  logic [7:0] sub_i,
    output logic [7:0] sub_o
);

    // Entry 0x00 occupies the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = {~sub_i, 3'b000};
    assign sub_o  = c_SBOX[w_base +: 8];

endmodule
`default_nettype wire

// File: rtl/aes128_inv_key_schedule.sv
`default_nettype none
// ============================================================================
//  Module      : aes128_inv_key_schedule
//  Description : Walks the AES-128 key expansion backward from the round-10
//                key, emitting round keys 10..0 over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes128_inv_key_schedule
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] last_key,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         busy,
    output logic         done
);

    state_t              state_q;
    logic [127:0]        key_q;
    logic [3:0]          idx_q;
    logic [BYTE-1:0]     rcon_q;
    logic                valid_q;
    logic                busy_q;
    logic                done_q;

    logic [WORD-1:0]     w_c0, w_c1, w_c2, w_c3;
    logic [WORD-1:0]     w_p0, w_p1, w_p2, w_p3;
    logic [WORD-1:0]     w_rot;
    logic [WORD-1:0]     w_sub;
    logic [127:0]        key_d;
    logic                w_accept;

    assign {w_c0, w_c1, w_c2, w_c3} = key_q;

    // Undo w[i] = w[i-4] ^ w[i-1]; only the first word needs the g-function.
    assign w_p3  = w_c3 ^ w_c2;
    assign w_p2  = w_c2 ^ w_c1;
    assign w_p1  = w_c1 ^ w_c0;
    assign w_rot = {w_p3[WORD-BYTE-1:0], w_p3[WORD-1:WORD-BYTE]};

    generate
        for (genvar i = 0; i < NK; i++) begin : g_subword
            aes_sbox u_sbox (
                .sub_i (w_rot[BYTE*i +: BYTE]),
                .sub_o (w_sub[BYTE*i +: BYTE])
            );
        end
    endgenerate

    assign w_p0     = w_c0 ^ w_sub ^ {rcon_q, 24'h000000};
    assign key_d    = {w_p0, w_p1, w_p2, w_p3};
    assign w_accept = valid_q & key_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            rcon_q  <= RCON_LAST;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q   <= last_key;
                        idx_q   <= ROUND_LAST;
                        rcon_q  <= RCON_LAST;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= EMIT;
                    end
                end
                EMIT: begin
                    if (w_accept) begin
                        if (idx_q != 4'd0) begin
                            key_q  <= key_d;
                            idx_q  <= idx_q - 4'd1;
                            rcon_q <= inv_xtime(rcon_q);
                        end else begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign key_valid = valid_q;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire
